// File: rtl/serial_rx_fifo.sv
// Oversampling source-synchronous serial receiver: synchronises RX_CLK/RX_DIN onto clk_i,
// deserialises DATA_WIDTH-bit words and queues them in a first-word-fall-through FIFO.
module serial_rx_fifo #(
    parameter int DATA_WIDTH    = 32,
    parameter int SERIAL_MODE   = 2,
    parameter bit SAMPLE_EDGE   = 1'b1,
    parameter bit MSB_FIRST     = 1'b1,
    parameter int TIMEOUT_CYC   = 16,
    parameter int FIFO_DEPTH    = 8,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            rx_en_i,
    input  logic                            RX_CLK,
    input  logic [SERIAL_MODE-1:0]          RX_DIN,
    output logic                            m_valid_o,
    input  logic                            m_ready_i,
    output logic [DATA_WIDTH-1:0]           m_data_o,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
    output logic                            frame_err_o,
    output logic [ERR_CNT_WIDTH-1:0]        frame_err_cnt_o,
    output logic [ERR_CNT_WIDTH-1:0]        ovf_cnt_o
);

    localparam int BEATS = DATA_WIDTH / SERIAL_MODE;
    localparam int BW    = $clog2(BEATS + 1);
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;

    logic                     rx_clk_meta_q, rx_clk_meta_d;
    logic                     rx_clk_sync_q, rx_clk_sync_d;
    logic                     rx_clk_prev_q, rx_clk_prev_d;
    logic [SERIAL_MODE-1:0]   rx_din_meta_q, rx_din_meta_d;
    logic [SERIAL_MODE-1:0]   rx_din_sync_q, rx_din_sync_d;
    logic [DATA_WIDTH-1:0]    sr_q, sr_d, sr_shift;
    logic [BW-1:0]            beat_cnt_q, beat_cnt_d;
    logic [TW-1:0]            tmo_cnt_q, tmo_cnt_d;
    logic                     push_q, push_d;
    logic                     frame_err_q, frame_err_d;
    logic [ERR_CNT_WIDTH-1:0] frame_err_cnt_q, frame_err_cnt_d;
    logic [ERR_CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]            level_q, level_d;
    logic [DATA_WIDTH-1:0]    mem [FIFO_DEPTH];

    logic edge_det, pop, push_ok;

    // The beat is taken from the data synchroniser stage that lines up with the edge detector.
    generate
        if (BEATS == 1) begin : g_single_beat
            assign sr_shift = rx_din_sync_q;
        end else if (MSB_FIRST) begin : g_msb_first
            assign sr_shift = {sr_q[DATA_WIDTH-SERIAL_MODE-1:0], rx_din_sync_q};
        end else begin : g_lsb_first
            assign sr_shift = {rx_din_sync_q, sr_q[DATA_WIDTH-1:SERIAL_MODE]};
        end
    endgenerate

    assign edge_det  = (rx_clk_sync_q != rx_clk_prev_q) && (rx_clk_sync_q == SAMPLE_EDGE);
    assign m_valid_o = (level_q != '0);
    assign pop       = m_valid_o && m_ready_i;
    assign push_ok   = push_q && ((level_q != LW'(FIFO_DEPTH)) || pop);

    always_comb begin
        rx_clk_meta_d   = RX_CLK;
        rx_clk_sync_d   = rx_clk_meta_q;
        rx_clk_prev_d   = rx_clk_sync_q;
        rx_din_meta_d   = RX_DIN;
        rx_din_sync_d   = rx_din_meta_q;
        sr_d            = sr_q;
        beat_cnt_d      = beat_cnt_q;
        tmo_cnt_d       = tmo_cnt_q;
        push_d          = 1'b0;
        frame_err_d     = 1'b0;
        frame_err_cnt_d = frame_err_cnt_q;
        ovf_cnt_d       = ovf_cnt_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        level_d         = level_q;

        if (!rx_en_i) begin
            sr_d       = '0;
            beat_cnt_d = '0;
            tmo_cnt_d  = '0;
        end else if (edge_det) begin
            sr_d      = sr_shift;
            tmo_cnt_d = '0;
            if (beat_cnt_q == BW'(BEATS - 1)) begin
                beat_cnt_d = '0;
                push_d     = 1'b1;
            end else begin
                beat_cnt_d = beat_cnt_q + BW'(1);
            end
        end else if (tmo_cnt_q != TW'(TIMEOUT_CYC)) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
            // Abort only on the transition into the saturated value, so one error per gap.
            if ((tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) && (beat_cnt_q != '0)) begin
                sr_d        = '0;
                beat_cnt_d  = '0;
                frame_err_d = 1'b1;
                if (frame_err_cnt_q != '1) frame_err_cnt_d = frame_err_cnt_q + ERR_CNT_WIDTH'(1);
            end
        end

        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_q && !push_ok && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + ERR_CNT_WIDTH'(1);
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rx_clk_meta_q   <= 1'b0;
            rx_clk_sync_q   <= 1'b0;
            rx_clk_prev_q   <= 1'b0;
            rx_din_meta_q   <= '0;
            rx_din_sync_q   <= '0;
            sr_q            <= '0;
            beat_cnt_q      <= '0;
            tmo_cnt_q       <= '0;
            push_q          <= 1'b0;
            frame_err_q     <= 1'b0;
            frame_err_cnt_q <= '0;
            ovf_cnt_q       <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            level_q         <= '0;
        end else begin
            rx_clk_meta_q   <= rx_clk_meta_d;
            rx_clk_sync_q   <= rx_clk_sync_d;
            rx_clk_prev_q   <= rx_clk_prev_d;
            rx_din_meta_q   <= rx_din_meta_d;
            rx_din_sync_q   <= rx_din_sync_d;
            sr_q            <= sr_d;
            beat_cnt_q      <= beat_cnt_d;
            tmo_cnt_q       <= tmo_cnt_d;
            push_q          <= push_d;
            frame_err_q     <= frame_err_d;
            frame_err_cnt_q <= frame_err_cnt_d;
            ovf_cnt_q       <= ovf_cnt_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            level_q         <= level_d;
        end
    end

    // Storage carries no reset; the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr_q] <= sr_q;
    end

    assign m_data_o        = m_valid_o ? mem[rd_ptr_q] : '0;
    assign fifo_level_o    = level_q;
    assign frame_err_o     = frame_err_q;
    assign frame_err_cnt_o = frame_err_cnt_q;
    assign ovf_cnt_o       = ovf_cnt_q;

endmodule
